vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of requesting channels, legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: VRAM address width.
REQ-003 Parameter DATA_W, default 16: VRAM data width.
REQ-004 Parameter MASK_W, default 4: VRAM byte-mask width.
REQ-005 Ports, one per line: name, direction, width, meaning:
- clk  in  1  single clock; all logic on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_sel_i  in  NUM_CH  per-channel request, held until acked.
- req_wr_i  in  NUM_CH  per-channel write(1)/read(0).
- req_lock_i  in  NUM_CH  per-channel burst lock.
- req_mask_i  in  NUM_CH*MASK_W  per-channel mask; channel k occupies slice k.
- req_addr_i  in  NUM_CH*ADDR_W  per-channel address; channel k occupies slice k.
- req_data_i  in  NUM_CH*DATA_W  per-channel write data; channel k occupies slice k.
- req_ack_o  out  NUM_CH  one-cycle completion pulse to the granted channel.
- req_data_o  out  DATA_W  read data, valid while req_ack_o is high.
- grant_o  out  NUM_CH  one-hot current owner; all zero in IDLE.
- vram_sel_o, vram_wr_o  out  1 each  VRAM strobe and direction.
- vram_mask_o, vram_addr_o, vram_data_out_o  out  MASK_W, ADDR_W, DATA_W  VRAM mask, address and write data.
- vram_data_in_i  in  DATA_W  VRAM read data, valid with vram_ack_i.
- vram_ack_i  in  1  VRAM transaction complete.

Function
REQ-006 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-007 In IDLE with any req_sel_i bit set, the arbiter SHALL pick a winner g, register that channel's wr/mask/addr/data onto the vram_* outputs, set vram_sel_o=1 and grant_o=onehot(g), and go to BUSY on the next edge.
REQ-008 In IDLE with no requests, the arbiter SHALL remain in IDLE with vram_sel_o=0 and grant_o=0.
REQ-009 Winner selection SHALL be round-robin: search from (last+1) mod NUM_CH upward with wrap-around; last is the most recently granted channel.
REQ-010 Lock rule: if req_lock_i[last] and req_sel_i[last] are both 1 in IDLE, the arbiter SHALL select g=last, overriding round-robin.
REQ-011 In BUSY, all vram_* outputs SHALL stay stable until vram_ack_i=1, with no timeout.
REQ-012 On a BUSY edge with vram_ack_i=1:
- state goes to DONE; vram_sel_o goes to 0.
- req_ack_o[g] goes to 1 for exactly one cycle.
- req_data_o captures vram_data_in_i on reads only and otherwise holds its previous value.
- last is set to g.
REQ-013 DONE SHALL last exactly one cycle and then return to IDLE; grant_o SHALL stay at onehot(g) through DONE and clear on entry to IDLE.
REQ-014 Request latency SHALL be: request seen in IDLE -> vram_sel_o high on the next edge; vram_ack_i -> req_ack_o on the next edge; minimum 3 cycles per transaction.
REQ-015 A requester SHALL drop req_sel_i, or present a new request, on the edge at which it samples req_ack_o=1; the arbiter SHALL NOT sample requests in DONE, so there is no double-issue.
REQ-016 Changes to req_* inputs of the granted channel while in BUSY SHALL have no effect on the vram_* outputs.
REQ-017 vram_ack_i SHALL be ignored in IDLE and DONE.
REQ-018 Simultaneous requests SHALL be resolved by REQ-009/REQ-010 only; exactly one channel is served per transaction.

Reset
REQ-019 When reset_i=0, the block SHALL immediately, without waiting for a clock, go to IDLE and force every output to zero: vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_out_o, req_ack_o, req_data_o, grant_o.
REQ-020 Reset SHALL set last=NUM_CH-1, so channel 0 has first priority after reset.
REQ-021 Reset asserted in BUSY SHALL abort the transaction with no req_ack_o pulse; a vram_ack_i arriving after reset release SHALL be ignored.

Verification
REQ-022 NUM_CH=2; ch0 write addr 0x10, data 0xBEEF, mask 0xF; vram_ack_i after 2 cycles -> vram_* carry these values; req_ack_o=01 for one cycle; 3 transactions take 4+ cycles each.
REQ-023 All 4 channels (NUM_CH=4) requesting continuously from reset -> grant order 0,1,2,3,0; no channel starved.
REQ-024 ch1 with req_lock_i=1 issues 3 back-to-back reads while ch0 also requests -> grants are 1,1,1 and then 0; req_data_o equals vram_data_in_i (e.g. 0x1234, 0x5678, 0x9ABC) in each ack cycle.
REQ-025 reset_i pulsed low mid-BUSY -> all outputs 0 immediately; no req_ack_o; next grant goes to ch0.
REQ-026 vram_ack_i held high continuously, single requester -> exactly one req_ack_o per transaction; no extra VRAM strobes; vram_sel_o is low in DONE and IDLE.

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Round-robin VRAM arbiter for NUM_CH requesters with burst lock.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16,
    parameter int MASK_W = 4
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic [NUM_CH-1:0]          req_sel_i,
    input  logic [NUM_CH-1:0]          req_wr_i,
    input  logic [NUM_CH-1:0]          req_lock_i,
    input  logic [NUM_CH*MASK_W-1:0]   req_mask_i,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]   req_data_i,
    output logic [NUM_CH-1:0]          req_ack_o,
    output logic [DATA_W-1:0]          req_data_o,
    output logic [NUM_CH-1:0]          grant_o,
    output logic                       vram_sel_o,
    output logic                       vram_wr_o,
    output logic [MASK_W-1:0]          vram_mask_o,
    output logic [ADDR_W-1:0]          vram_addr_o,
    output logic [DATA_W-1:0]          vram_data_out_o,
    input  logic [DATA_W-1:0]          vram_data_in_i,
    input  logic                       vram_ack_i
);

    localparam int LAST_W = $clog2(NUM_CH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [LAST_W-1:0]   r_last;
    logic [LAST_W-1:0]   r_gidx;
    logic                r_vram_sel;
    logic                r_vram_wr;
    logic [MASK_W-1:0]   r_vram_mask;
    logic [ADDR_W-1:0]   r_vram_addr;
    logic [DATA_W-1:0]   r_vram_data;
    logic [NUM_CH-1:0]   r_req_ack;
    logic [DATA_W-1:0]   r_req_data;
    logic [NUM_CH-1:0]   r_grant;

    logic [LAST_W-1:0]   w_last_nxt;
    logic [LAST_W-1:0]   w_gidx_nxt;
    logic                w_vram_sel_nxt;
    logic                w_vram_wr_nxt;
    logic [MASK_W-1:0]   w_vram_mask_nxt;
    logic [ADDR_W-1:0]   w_vram_addr_nxt;
    logic [DATA_W-1:0]   w_vram_data_nxt;
    logic [NUM_CH-1:0]   w_req_ack_nxt;
    logic [DATA_W-1:0]   w_req_data_nxt;
    logic [NUM_CH-1:0]   w_grant_nxt;

    logic                w_any;
    logic                w_found;
    logic [LAST_W-1:0]   w_cand;
    logic [LAST_W-1:0]   w_win;
    logic                w_sel_wr;
    logic [MASK_W-1:0]   w_sel_mask;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    assign w_any = |req_sel_i;

    // A locked, still-requesting previous owner keeps the bus; otherwise
    // search upward from last+1 with wrap-around.
    always_comb begin
        w_win   = r_last;
        w_found = 1'b0;
        w_cand  = '0;
        if (req_lock_i[r_last] && req_sel_i[r_last]) begin
            w_found = 1'b1;
        end
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = LAST_W'((int'(r_last) + i) % NUM_CH);
            if (!w_found && req_sel_i[w_cand]) begin
                w_win   = w_cand;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_wr   = 1'b0;
        w_sel_mask = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_win == LAST_W'(k)) begin
                w_sel_wr   = req_wr_i[k];
                w_sel_mask = req_mask_i[k*MASK_W +: MASK_W];
                w_sel_addr = req_addr_i[k*ADDR_W +: ADDR_W];
                w_sel_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= S_IDLE;
            r_last      <= LAST_W'(NUM_CH - 1);
            r_gidx      <= '0;
            r_vram_sel  <= 1'b0;
            r_vram_wr   <= 1'b0;
            r_vram_mask <= '0;
            r_vram_addr <= '0;
            r_vram_data <= '0;
            r_req_ack   <= '0;
            r_req_data  <= '0;
            r_grant     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_gidx      <= w_gidx_nxt;
            r_vram_sel  <= w_vram_sel_nxt;
            r_vram_wr   <= w_vram_wr_nxt;
            r_vram_mask <= w_vram_mask_nxt;
            r_vram_addr <= w_vram_addr_nxt;
            r_vram_data <= w_vram_data_nxt;
            r_req_ack   <= w_req_ack_nxt;
            r_req_data  <= w_req_data_nxt;
            r_grant     <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_BUSY;
            S_BUSY:  if (vram_ack_i) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; anything not assigned holds.
    always_comb begin
        w_last_nxt      = r_last;
        w_gidx_nxt      = r_gidx;
        w_vram_sel_nxt  = r_vram_sel;
        w_vram_wr_nxt   = r_vram_wr;
        w_vram_mask_nxt = r_vram_mask;
        w_vram_addr_nxt = r_vram_addr;
        w_vram_data_nxt = r_vram_data;
        w_req_ack_nxt   = '0;
        w_req_data_nxt  = r_req_data;
        w_grant_nxt     = r_grant;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gidx_nxt      = w_win;
                    w_vram_sel_nxt  = 1'b1;
                    w_vram_wr_nxt   = w_sel_wr;
                    w_vram_mask_nxt = w_sel_mask;
                    w_vram_addr_nxt = w_sel_addr;
                    w_vram_data_nxt = w_sel_data;
                    w_grant_nxt     = NUM_CH'(1) << w_win;
                end else begin
                    w_vram_sel_nxt  = 1'b0;
                    w_grant_nxt     = '0;
                end
            end
            S_BUSY: begin
                if (vram_ack_i) begin
                    w_vram_sel_nxt = 1'b0;
                    w_req_ack_nxt  = r_grant;
                    w_last_nxt     = r_gidx;
                    if (!r_vram_wr) w_req_data_nxt = vram_data_in_i;
                end
            end
            S_DONE: begin
                w_grant_nxt = '0;
            end
            default: begin
                w_vram_sel_nxt = 1'b0;
                w_grant_nxt    = '0;
            end
        endcase
    end

    assign req_ack_o       = r_req_ack;
    assign req_data_o      = r_req_data;
    assign grant_o         = r_grant;
    assign vram_sel_o      = r_vram_sel;
    assign vram_wr_o       = r_vram_wr;
    assign vram_mask_o     = r_vram_mask;
    assign vram_addr_o     = r_vram_addr;
    assign vram_data_out_o = r_vram_data;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed self-checking bench for vram_arbiter (4 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int MW  = 4;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [NCH-1:0]      req_sel_i;
    logic [NCH-1:0]      req_wr_i;
    logic [NCH-1:0]      req_lock_i;
    logic [NCH*MW-1:0]   req_mask_i;
    logic [NCH*AW-1:0]   req_addr_i;
    logic [NCH*DW-1:0]   req_data_i;
    logic [NCH-1:0]      req_ack_o;
    logic [DW-1:0]       req_data_o;
    logic [NCH-1:0]      grant_o;
    logic                vram_sel_o;
    logic                vram_wr_o;
    logic [MW-1:0]       vram_mask_o;
    logic [AW-1:0]       vram_addr_o;
    logic [DW-1:0]       vram_data_out_o;
    logic [DW-1:0]       vram_data_in_i;
    logic                vram_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    int          order [5] = '{0, 1, 2, 3, 0};
    logic [15:0] rdat  [3] = '{16'h1234, 16'h5678, 16'h9ABC};
    int          acks;
    int          strobes;

    always #5 clk = ~clk;

    vram_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .req_sel_i       (req_sel_i),
        .req_wr_i        (req_wr_i),
        .req_lock_i      (req_lock_i),
        .req_mask_i      (req_mask_i),
        .req_addr_i      (req_addr_i),
        .req_data_i      (req_data_i),
        .req_ack_o       (req_ack_o),
        .req_data_o      (req_data_o),
        .grant_o         (grant_o),
        .vram_sel_o      (vram_sel_o),
        .vram_wr_o       (vram_wr_o),
        .vram_mask_o     (vram_mask_o),
        .vram_addr_o     (vram_addr_o),
        .vram_data_out_o (vram_data_out_o),
        .vram_data_in_i  (vram_data_in_i),
        .vram_ack_i      (vram_ack_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel"},   64'(vram_sel_o),      64'h0);
        chk({tag, "_wr"},    64'(vram_wr_o),       64'h0);
        chk({tag, "_mask"},  64'(vram_mask_o),     64'h0);
        chk({tag, "_addr"},  64'(vram_addr_o),     64'h0);
        chk({tag, "_dout"},  64'(vram_data_out_o), 64'h0);
        chk({tag, "_ack"},   64'(req_ack_o),       64'h0);
        chk({tag, "_rdata"}, 64'(req_data_o),      64'h0);
        chk({tag, "_grant"}, 64'(grant_o),         64'h0);
    endtask

    task automatic set_ch(input int k, input logic wr, input logic [MW-1:0] m,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr_i[k]              = wr;
        req_mask_i[k*MW +: MW]   = m;
        req_addr_i[k*AW +: AW]   = a;
        req_data_i[k*DW +: DW]   = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset_i        = 1'b0;
        req_sel_i      = '0;
        req_wr_i       = '0;
        req_lock_i     = '0;
        req_mask_i     = '0;
        req_addr_i     = '0;
        req_data_i     = '0;
        vram_data_in_i = '0;
        vram_ack_i     = 1'b0;
        repeat (2) step();
        chk_zero("reset");
        reset_i = 1'b1;
        step();
        chk("idle_noreq_sel",   64'(vram_sel_o), 64'h0);
        chk("idle_noreq_grant", 64'(grant_o),    64'h0);

        // Single write from ch0, ack two cycles into BUSY
        set_ch(0, 1'b1, 4'hF, 32'h10, 16'hBEEF);
        req_sel_i = 4'b0001;
        step();
        chk("wr_sel",   64'(vram_sel_o),      64'h1);
        chk("wr_wr",    64'(vram_wr_o),       64'h1);
        chk("wr_mask",  64'(vram_mask_o),     64'hF);
        chk("wr_addr",  64'(vram_addr_o),     64'h10);
        chk("wr_dout",  64'(vram_data_out_o), 64'hBEEF);
        chk("wr_grant", 64'(grant_o),         64'h1);
        chk("wr_noack", 64'(req_ack_o),       64'h0);
        set_ch(0, 1'b0, 4'h3, 32'h99, 16'h0BAD);
        step();
        chk("busy_addr_stable", 64'(vram_addr_o),     64'h10);
        chk("busy_dout_stable", 64'(vram_data_out_o), 64'hBEEF);
        chk("busy_wr_stable",   64'(vram_wr_o),       64'h1);
        chk("busy_sel_stable",  64'(vram_sel_o),      64'h1);
        vram_ack_i = 1'b1;
        step();
        chk("done_ack",   64'(req_ack_o),  64'h1);
        chk("done_sel",   64'(vram_sel_o), 64'h0);
        chk("done_grant", 64'(grant_o),    64'h1);
        req_sel_i  = '0;
        vram_ack_i = 1'b0;
        step();
        chk("idle_ack",   64'(req_ack_o),  64'h0);
        chk("idle_grant", 64'(grant_o),    64'h0);
        chk("wr_rdata",   64'(req_data_o), 64'h0);

        // Round robin from reset, all four channels, ack held high
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        for (int k = 0; k < NCH; k++) set_ch(k, 1'b0, 4'h1, 32'h100 + 32'(k), 16'h0);
        req_sel_i      = 4'b1111;
        vram_ack_i     = 1'b1;
        vram_data_in_i = 16'hA5A5;
        for (int t = 0; t < 5; t++) begin
            step();
            chk("rr_grant", 64'(grant_o),     64'(4'b0001 << order[t]));
            chk("rr_sel",   64'(vram_sel_o),  64'h1);
            chk("rr_addr",  64'(vram_addr_o), 64'h100 + 64'(order[t]));
            step();
            chk("rr_ack",      64'(req_ack_o),  64'(4'b0001 << order[t]));
            chk("rr_done_sel", 64'(vram_sel_o), 64'h0);
            step();
            chk("rr_idle_grant", 64'(grant_o),    64'h0);
            chk("rr_idle_ack",   64'(req_ack_o),  64'h0);
            chk("rr_idle_sel",   64'(vram_sel_o), 64'h0);
        end
        req_sel_i  = '0;
        vram_ack_i = 1'b0;
        step();

        // Locked burst of reads on ch1 while ch0 also requests
        set_ch(0, 1'b0, 4'h1, 32'h200, 16'h0);
        set_ch(1, 1'b0, 4'h1, 32'h300, 16'h0);
        req_sel_i  = 4'b0011;
        req_lock_i = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lock_grant", 64'(grant_o),     64'h2);
            chk("lock_addr",  64'(vram_addr_o), 64'h300);
            vram_ack_i     = 1'b1;
            vram_data_in_i = rdat[i];
            step();
            chk("lock_ack",   64'(req_ack_o),  64'h2);
            chk("lock_rdata", 64'(req_data_o), 64'(rdat[i]));
            vram_ack_i = 1'b0;
            if (i == 2) begin
                req_sel_i  = 4'b0001;
                req_lock_i = '0;
            end
            step();
        end
        step();
        chk("unlock_grant", 64'(grant_o), 64'h1);
        vram_ack_i     = 1'b1;
        vram_data_in_i = 16'h4321;
        step();
        chk("unlock_ack",   64'(req_ack_o),  64'h1);
        chk("unlock_rdata", 64'(req_data_o), 64'h4321);
        vram_ack_i = 1'b0;
        req_sel_i  = '0;
        step();

        // Asynchronous reset in the middle of a ch1 transaction
        set_ch(1, 1'b1, 4'h7, 32'h400, 16'h7777);
        req_sel_i = 4'b0010;
        step();
        chk("pre_rst_grant", 64'(grant_o),    64'h2);
        chk("pre_rst_sel",   64'(vram_sel_o), 64'h1);
        #2 reset_i = 1'b0;
        #1 chk_zero("async_rst");
        vram_ack_i = 1'b1;
        step();
        reset_i   = 1'b1;
        req_sel_i = '0;
        step();
        chk("post_rst_noack", 64'(req_ack_o),  64'h0);
        chk("post_rst_sel",   64'(vram_sel_o), 64'h0);
        req_sel_i = 4'b0011;
        step();
        chk("post_rst_grant", 64'(grant_o), 64'h1);
        step();
        chk("post_rst_ack", 64'(req_ack_o), 64'h1);
        req_sel_i  = '0;
        vram_ack_i = 1'b0;
        step();

        // Single requester with ack stuck high: one strobe and one ack per transaction
        set_ch(3, 1'b0, 4'h2, 32'h500, 16'h0);
        req_sel_i  = 4'b1000;
        vram_ack_i = 1'b1;
        acks    = 0;
        strobes = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (req_ack_o != '0) acks++;
            if (vram_sel_o) strobes++;
        end
        chk("stuck_ack_count",    64'(acks),    64'd2);
        chk("stuck_strobe_count", 64'(strobes), 64'd2);
        req_sel_i  = '0;
        vram_ack_i = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
